// File: rtl/tlb_inv_walker.sv
// INVTLB walker: sweeps every TLB entry once per command and clears the E bit
// of each entry that matches the op-selected ASID/VPPN/G criteria.
module tlb_inv_walker #(
   parameter  int unsigned TLBNUM = 16,
   localparam int unsigned IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [4:0]    op,
   input  logic [9:0]    asid,
   input  logic [18:0]   vppn,
   output logic          busy,
   output logic          done,
   output logic          op_err,
   output logic [IW:0]   inv_cnt,
   output logic [IW-1:0] r_index,
   input  logic          r_e,
   input  logic          r_g,
   input  logic [18:0]   r_vppn,
   input  logic [5:0]    r_ps,
   input  logic [9:0]    r_asid,
   output logic          we,
   output logic [IW-1:0] w_index,
   output logic          w_e
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic [4:0]    op_q;
   logic [9:0]    asid_q;
   logic [18:0]   vppn_q;
   logic [IW-1:0] idx;
   logic [IW:0]   cnt;
   logic          err_q;

   logic          op_ok;
   logic          last;
   logic          vmatch;
   logic          amatch;
   logic          cond;
   logic          hit;
   logic          wr;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      op_ok    = (op <= 5'd6);
      last     = (idx == IW'(TLBNUM - 1));
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = op_ok ? WALK : DONE;
            end
         end
         WALK: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- entry match
   always_comb begin
      if (r_ps == 6'd22) begin
         vmatch = (r_vppn[18:9] == vppn_q[18:9]);
      end else begin
         vmatch = (r_vppn == vppn_q);
      end
      amatch = (r_asid == asid_q);
      case (op_q)
         5'd0, 5'd1: cond = 1'b1;
         5'd2:       cond = r_g;
         5'd3:       cond = !r_g;
         5'd4:       cond = !r_g && amatch;
         5'd5:       cond = !r_g && amatch && vmatch;
         5'd6:       cond = (r_g || amatch) && vmatch;
         default:    cond = 1'b0;
      endcase
      hit = r_e && cond;
   end

   // ---------------------------------------------------------------- outputs
   // reset gates the write strobe in the same cycle so an aborted walk
   // clears nothing beyond the entries already visited
   always_comb begin
      wr      = (state == WALK) && hit && !reset;
      busy    = (state == WALK);
      done    = (state == DONE);
      we      = wr;
      r_index = (state == WALK) ? idx : '0;
      w_index = r_index;
      w_e     = 1'b0;
      op_err  = err_q;
      inv_cnt = cnt;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= '0;
         asid_q <= '0;
         vppn_q <= '0;
         idx    <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= op;
                  asid_q <= asid;
                  vppn_q <= vppn;
                  idx    <= '0;
                  cnt    <= '0;
                  err_q  <= !op_ok;
               end
            end
            WALK: begin
               idx <= idx + IW'(1);
               if (wr) begin
                  cnt <= cnt + (IW+1)'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_inv_walker.sv
// Directed bench for tlb_inv_walker with a 16-entry behavioural TLB on the
// read/write ports.
module tb_tlb_inv_walker;

   localparam int unsigned N  = 16;
   localparam int unsigned IW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [4:0]    op;
   logic [9:0]    asid;
   logic [18:0]   vppn;
   logic          busy;
   logic          done;
   logic          op_err;
   logic [IW:0]   inv_cnt;
   logic [IW-1:0] r_index;
   logic          r_e;
   logic          r_g;
   logic [18:0]   r_vppn;
   logic [5:0]    r_ps;
   logic [9:0]    r_asid;
   logic          we;
   logic [IW-1:0] w_index;
   logic          w_e;

   logic          tlb_e    [N];
   logic          tlb_g    [N];
   logic [18:0]   tlb_vppn [N];
   logic [5:0]    tlb_ps   [N];
   logic [9:0]    tlb_asid [N];
   logic          load;
   logic          ps22_mode;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tlb_inv_walker #(.TLBNUM(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .asid    (asid),
      .vppn    (vppn),
      .busy    (busy),
      .done    (done),
      .op_err  (op_err),
      .inv_cnt (inv_cnt),
      .r_index (r_index),
      .r_e     (r_e),
      .r_g     (r_g),
      .r_vppn  (r_vppn),
      .r_ps    (r_ps),
      .r_asid  (r_asid),
      .we      (we),
      .w_index (w_index),
      .w_e     (w_e)
   );

   always_comb begin
      r_e    = tlb_e[r_index];
      r_g    = tlb_g[r_index];
      r_vppn = tlb_vppn[r_index];
      r_ps   = tlb_ps[r_index];
      r_asid = tlb_asid[r_index];
   end

   // even entries global, odd entries ASID 5, entry 3 holds VPPN 0x12345
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < N; i++) begin
            tlb_e[i]    <= 1'b1;
            tlb_g[i]    <= (i % 2 == 0);
            tlb_asid[i] <= (i % 2 == 1) ? 10'h005 : 10'h00A;
            tlb_vppn[i] <= (i == 3) ? 19'h12345 : 19'(i << 4);
            tlb_ps[i]   <= (i == 3 && ps22_mode) ? 6'd22 : 6'd12;
         end
      end else if (we) begin
         tlb_e[w_index] <= w_e;
      end
   end

   function automatic logic [15:0] e_vec();
      logic [15:0] v;
      for (int i = 0; i < N; i++) v[i] = tlb_e[i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_tlb(input logic ps22);
      ps22_mode = ps22;
      load      = 1'b1;
      @(posedge clk); #1;
      load      = 1'b0;
   endtask

   // Issues a command in the current cycle (T) and waits for done.
   // lat is the cycle offset of done from T, -1 on timeout.
   task automatic run_cmd(input logic [4:0] o, input logic [9:0] a, input logic [18:0] v,
                          input int second_k, output int lat, output int we_n,
                          output int busy_n);
      lat    = -1;
      we_n   = 0;
      busy_n = 0;
      op     = o;
      asid   = a;
      vppn   = v;
      start  = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) start = 1'b0;
         if (second_k != 0 && k == second_k + 1) start = 1'b0;
         if (second_k != 0 && k == second_k) begin
            start = 1'b1;
            op    = 5'd2;
            asid  = 10'h3FF;
            vppn  = 19'h7FFFF;
         end
         if (we) we_n++;
         if (busy) busy_n++;
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int lat, we_n, busy_n;
      reset     = 1'b1;
      start     = 1'b0;
      op        = '0;
      asid      = '0;
      vppn      = '0;
      load      = 1'b0;
      ps22_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_we",      32'(we),      32'd0);
      check("rst_rindex",  32'(r_index), 32'd0);
      check("rst_invcnt",  32'(inv_cnt), 32'd0);
      check("rst_operr",   32'(op_err),  32'd0);

      // op 0: clear everything
      load_tlb(1'b0);
      run_cmd(5'd0, 10'h000, 19'h00000, 0, lat, we_n, busy_n);
      check("op0_lat",    32'(lat),     32'd17);
      check("op0_we",     32'(we_n),    32'd16);
      check("op0_busy",   32'(busy_n),  32'd16);
      check("op0_cnt",    32'(inv_cnt), 32'd16);
      check("op0_err",    32'(op_err),  32'd0);
      @(posedge clk); #1;
      check("op0_e",      32'(e_vec()), 32'h0000);
      check("op0_done1",  32'(done),    32'd0);
      check("op0_hold",   32'(inv_cnt), 32'd16);

      // op 2: global entries only
      load_tlb(1'b0);
      run_cmd(5'd2, 10'h000, 19'h00000, 0, lat, we_n, busy_n);
      check("op2_lat",    32'(lat),     32'd17);
      check("op2_we",     32'(we_n),    32'd8);
      check("op2_cnt",    32'(inv_cnt), 32'd8);
      @(posedge clk); #1;
      check("op2_e",      32'(e_vec()), 32'hAAAA);

      // op 5, 4K page match on entry 3
      load_tlb(1'b0);
      run_cmd(5'd5, 10'h005, 19'h12345, 0, lat, we_n, busy_n);
      check("op5_lat",    32'(lat),     32'd17);
      check("op5_cnt",    32'(inv_cnt), 32'd1);
      @(posedge clk); #1;
      check("op5_e",      32'(e_vec()), 32'hFFF7);

      // op 5, 4M page: only VPPN[18:9] compared
      load_tlb(1'b1);
      run_cmd(5'd5, 10'h005, 19'h12200, 0, lat, we_n, busy_n);
      check("op5ps22_cnt", 32'(inv_cnt), 32'd1);
      @(posedge clk); #1;
      check("op5ps22_e",  32'(e_vec()), 32'hFFF7);

      // illegal op
      load_tlb(1'b0);
      run_cmd(5'd7, 10'h000, 19'h00000, 0, lat, we_n, busy_n);
      check("op7_lat",    32'(lat),     32'd1);
      check("op7_err",    32'(op_err),  32'd1);
      check("op7_cnt",    32'(inv_cnt), 32'd0);
      check("op7_we",     32'(we_n),    32'd0);
      check("op7_busy",   32'(busy_n),  32'd0);
      // start coincident with done is dropped
      op    = 5'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("startdone_busy", 32'(busy),    32'd0);
      check("startdone_done", 32'(done),    32'd0);
      check("op7_errhold",    32'(op_err),  32'd1);
      check("op7_e",          32'(e_vec()), 32'hFFFF);

      // second start during the walk is ignored
      load_tlb(1'b0);
      run_cmd(5'd0, 10'h000, 19'h00000, 5, lat, we_n, busy_n);
      check("ign_lat",    32'(lat),     32'd17);
      check("ign_we",     32'(we_n),    32'd16);
      check("ign_cnt",    32'(inv_cnt), 32'd16);
      check("ign_err",    32'(op_err),  32'd0);
      @(posedge clk); #1;
      check("ign_e",      32'(e_vec()), 32'h0000);

      // reset in cycle T+6 aborts the walk after entries 0..4
      load_tlb(1'b0);
      op    = 5'd0;
      start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 1) start = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("abort_we",     32'(we),      32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy",   32'(busy),    32'd0);
      check("abort_done",   32'(done),    32'd0);
      check("abort_we2",    32'(we),      32'd0);
      check("abort_rindex", 32'(r_index), 32'd0);
      check("abort_cnt",    32'(inv_cnt), 32'd0);
      check("abort_e",      32'(e_vec()), 32'hFFE0);

      // fresh walk clears the remaining 11 entries
      run_cmd(5'd0, 10'h000, 19'h00000, 0, lat, we_n, busy_n);
      check("fresh_lat",  32'(lat),     32'd17);
      check("fresh_cnt",  32'(inv_cnt), 32'd11);
      @(posedge clk); #1;
      check("fresh_e",    32'(e_vec()), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
